// File: rtl/mover_2d_activation_lanes.sv
// Multi-lane activation stage for the mover_2d output path: two register stages
// with valid/ready back-pressure, per-packet function latching and saturating stats.
module mover_2d_activation_lanes #(
    parameter int          LANES                 = 4,
    parameter int          DATA_WIDTH            = 16,
    parameter int          USER_WIDTH            = 8,
    parameter int          STAT_WIDTH            = 32,
    parameter logic [3:0]  ACTIV_FUNC_BYPASS     = 4'h0,
    parameter logic [3:0]  ACTIV_FUNC_RELU       = 4'h1,
    parameter logic [3:0]  ACTIV_FUNC_LEAKY_RELU = 4'h2,
    parameter logic [3:0]  ACTIV_FUNC_RELU_CLIP  = 4'h5,
    parameter logic [3:0]  ACTIV_FUNC_HARD_TANH  = 4'h6
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [3:0]                    ACTIV_FUNC,
    input  logic [DATA_WIDTH-1:0]         ACTIV_PARAM,
    output logic                          IN_READY,
    input  logic                          IN_VALID,
    input  logic [LANES*DATA_WIDTH-1:0]   IN_DATA,
    input  logic [USER_WIDTH-1:0]         IN_USER,
    input  logic                          IN_LAST,
    input  logic                          OUT_READY,
    output logic                          OUT_VALID,
    output logic [LANES*DATA_WIDTH-1:0]   OUT_DATA,
    output logic [USER_WIDTH-1:0]         OUT_USER,
    output logic                          OUT_LAST,
    input  logic                          STAT_CLR,
    output logic [STAT_WIDTH-1:0]         STAT_MOD_CNT,
    output logic [STAT_WIDTH-1:0]         STAT_PKT_CNT
);

    localparam int CNT_W = $clog2(LANES + 1);

    typedef enum logic {
        ST_IDLE,
        ST_PKT
    } state_t;

    state_t                         r_state;
    logic [3:0]                     r_func_q;
    logic [DATA_WIDTH-1:0]          r_param_q;

    logic                           r_s1_valid;
    logic [LANES*DATA_WIDTH-1:0]    r_s1_data;
    logic [USER_WIDTH-1:0]          r_s1_user;
    logic                           r_s1_last;

    logic                           w_enable;
    logic                           w_acc;
    logic                           w_pkt_done;
    logic [3:0]                     w_func;
    logic [DATA_WIDTH-1:0]          w_param;
    logic [DATA_WIDTH-1:0]          w_lane;
    logic [LANES*DATA_WIDTH-1:0]    w_result;
    logic [CNT_W-1:0]               w_mod_lanes;
    logic [STAT_WIDTH:0]            w_mod_sum;

    function automatic logic [DATA_WIDTH-1:0] f_activate(
        input logic [3:0]                   func,
        input logic signed [DATA_WIDTH-1:0] p,
        input logic signed [DATA_WIDTH-1:0] x
    );
        logic signed [DATA_WIDTH-1:0] pc;
        logic signed [DATA_WIDTH-1:0] res;
        logic [4:0]                   shamt;
        pc  = p[DATA_WIDTH-1] ? '0 : p;
        res = x;
        if (int'(p[4:0]) > DATA_WIDTH - 1)
            shamt = 5'(DATA_WIDTH - 1);
        else
            shamt = p[4:0];
        case (func)
            ACTIV_FUNC_RELU: begin
                if (x[DATA_WIDTH-1]) res = '0;
            end
            ACTIV_FUNC_LEAKY_RELU: begin
                if (x[DATA_WIDTH-1]) res = x >>> shamt;
            end
            ACTIV_FUNC_RELU_CLIP: begin
                if (x[DATA_WIDTH-1]) res = '0;
                else if (x > pc)     res = pc;
            end
            ACTIV_FUNC_HARD_TANH: begin
                // -pc cannot overflow: pc is never negative
                if (x > pc)       res = pc;
                else if (x < -pc) res = -pc;
            end
            default: res = x;
        endcase
        return res;
    endfunction

    assign w_enable   = OUT_READY | ~OUT_VALID;
    assign IN_READY   = w_enable;
    assign w_acc      = IN_VALID & w_enable;
    assign w_pkt_done = OUT_VALID & OUT_READY & OUT_LAST;

    // The first beat of a packet uses the live config; later beats use the latched copy
    always_comb begin
        w_func      = (r_state == ST_IDLE) ? ACTIV_FUNC  : r_func_q;
        w_param     = (r_state == ST_IDLE) ? ACTIV_PARAM : r_param_q;
        w_result    = '0;
        w_mod_lanes = '0;
        w_lane      = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_lane = f_activate(w_func, w_param, IN_DATA[i*DATA_WIDTH +: DATA_WIDTH]);
            w_result[i*DATA_WIDTH +: DATA_WIDTH] = w_lane;
            if (w_lane != IN_DATA[i*DATA_WIDTH +: DATA_WIDTH])
                w_mod_lanes = w_mod_lanes + 1'b1;
        end
    end

    assign w_mod_sum = {1'b0, STAT_MOD_CNT} + {{(STAT_WIDTH + 1 - CNT_W){1'b0}}, w_mod_lanes};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_func_q  <= '0;
            r_param_q <= '0;
        end else if (w_acc) begin
            case (r_state)
                ST_IDLE: begin
                    r_func_q  <= ACTIV_FUNC;
                    r_param_q <= ACTIV_PARAM;
                    if (!IN_LAST) r_state <= ST_PKT;
                end
                ST_PKT: begin
                    if (IN_LAST) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Both stages advance together, so a stage1 bubble is held during a stall
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_user  <= '0;
            r_s1_last  <= 1'b0;
            OUT_VALID  <= 1'b0;
            OUT_DATA   <= '0;
            OUT_USER   <= '0;
            OUT_LAST   <= 1'b0;
        end else if (w_enable) begin
            r_s1_valid <= IN_VALID;
            r_s1_data  <= w_result;
            r_s1_user  <= IN_USER;
            r_s1_last  <= IN_LAST;
            OUT_VALID  <= r_s1_valid;
            OUT_DATA   <= r_s1_data;
            OUT_USER   <= r_s1_user;
            OUT_LAST   <= r_s1_last;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || STAT_CLR) begin
            STAT_MOD_CNT <= '0;
            STAT_PKT_CNT <= '0;
        end else begin
            if (w_acc)
                STAT_MOD_CNT <= w_mod_sum[STAT_WIDTH] ? '1 : w_mod_sum[STAT_WIDTH-1:0];
            if (w_pkt_done && (STAT_PKT_CNT != '1))
                STAT_PKT_CNT <= STAT_PKT_CNT + 1'b1;
        end
    end

endmodule

// File: doc/mover_2d_activation_lanes.md
Name: mover_2d_activation_lanes

Overview:
- Multi-lane, 2-stage pipelined activation unit on the mover_2d output path, between the accumulator stream and the write mover.
- Applies one activation function to LANES signed integer/fixed-point elements per beat, with valid/ready back-pressure.
- Latches the function and parameter per packet, so the configuration is stable across a tensor row/plane.
- Keeps saturating statistics counters for modified elements and completed packets.

Parameters:
- LANES, 4, elements per beat.
- DATA_WIDTH, 16, element width; two's complement.
- USER_WIDTH, 8, sideband width; passed through unchanged.
- STAT_WIDTH, 32, statistics counter width.
- ACTIV_FUNC_BYPASS, 4'h0, pass-through.
- ACTIV_FUNC_RELU, 4'h1, max(x,0).
- ACTIV_FUNC_LEAKY_RELU, 4'h2, x<0 ? x>>>P : x.
- ACTIV_FUNC_RELU_CLIP, 4'h5, clamp(x, 0, P) (ReLU6-style).
- ACTIV_FUNC_HARD_TANH, 4'h6, clamp(x, -P, P).

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- ACTIV_FUNC  in  4  function select; sampled on the first beat of each packet.
- ACTIV_PARAM  in  DATA_WIDTH  parameter P; sampled with ACTIV_FUNC.
- IN_READY  out  1  input accept.
- IN_VALID  in  1  input valid.
- IN_DATA  in  LANES*DATA_WIDTH  elements; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- IN_USER  in  USER_WIDTH  sideband.
- IN_LAST  in  1  last beat of packet.
- OUT_READY  in  1  downstream accept.
- OUT_VALID  out  1  output valid.
- OUT_DATA  out  LANES*DATA_WIDTH  results.
- OUT_USER  out  USER_WIDTH  delayed IN_USER.
- OUT_LAST  out  1  delayed IN_LAST.
- STAT_CLR  in  1  synchronous clear of both counters.
- STAT_MOD_CNT  out  STAT_WIDTH  count of lanes whose output differs from input.
- STAT_PKT_CNT  out  STAT_WIDTH  packets completed at the output.

Behaviour:
- Reset (RESET=1 at a CLK edge) clears everything to 0: OUT_VALID, OUT_DATA, OUT_USER, OUT_LAST, both counters, both stage valids, func_q, param_q. The FSM returns to IDLE.
- Reset mid-packet discards all in-flight beats; no partial packet is emitted.
- Handshake and pipeline:
  - enable = OUT_READY | ~OUT_VALID; IN_READY = enable, combinational.
  - When enable=1, stage1 captures the input beat and stage2 (the output registers) captures stage1.
  - When enable=0, both stages hold.
  - Latency is exactly 2 cycles from input accept to OUT_VALID when not stalled. Throughput is 1 beat/cycle.
  - A stage1 bubble is not collapsed during a stall.
  - OUT_* remain stable while OUT_VALID=1 and OUT_READY=0.
- FSM, which tracks input acceptance (acc = IN_VALID & IN_READY):
  - IDLE: on acc, latch func_q=ACTIV_FUNC and param_q=ACTIV_PARAM. The beat itself uses the live ACTIV_FUNC/ACTIV_PARAM. Go to PKT unless IN_LAST=1 (single-beat packet stays in IDLE).
  - PKT: beats use func_q/param_q and changes on ACTIV_* are ignored. On acc with IN_LAST=1, go to IDLE.
- Arithmetic (stage1, per lane, signed):
  - RELU: x<0 → 0.
  - LEAKY_RELU: shift s = min(P[4:0], DATA_WIDTH-1). Arithmetic shift, rounds toward −inf (−5>>>1 = −3); a negative result never becomes positive.
  - RELU_CLIP: Pc = (P<0) ? 0 : P. Result is x<0 → 0, x>Pc → Pc, else x.
  - HARD_TANH: Pc as above. Result is x>Pc → Pc, x<−Pc → −Pc. −Pc is always representable because Pc ≤ max positive.
  - Codes 3, 4 and all undefined codes behave as BYPASS.
- Statistics:
  - mod_lanes = popcount of lanes where the stage1 result ≠ input.
  - STAT_MOD_CNT += mod_lanes on each input accept.
  - STAT_PKT_CNT += 1 on each output transfer (OUT_VALID & OUT_READY & OUT_LAST).
  - Both counters saturate at all-ones.
  - STAT_CLR has priority over a same-cycle increment; the counter becomes 0.

Test Plan:
- RELU, LANES=4, DATA_WIDTH=16, IN_DATA lanes {−3, 0, 7, −32768}, OUT_READY=1 → OUT_DATA {0, 0, 7, 0} two cycles after accept; STAT_MOD_CNT=2.
- LEAKY_RELU P=1 on {−5, −1, 4, −32768} → {−3, −1, 4, −16384}. P=31 on −5 → s=15, result −1.
- RELU_CLIP P=6 on {−2, 3, 6, 100} → {0, 3, 6, 6}. P=−4 on the same input → {0, 0, 0, 0}.
- HARD_TANH P=10 on {−11, −10, 9, 12} → {−10, −10, 9, 10}; STAT_MOD_CNT +2.
- 3-beat packet: start with RELU; switch ACTIV_FUNC to BYPASS on beat 2 → all 3 beats use RELU. The next packet starts with BYPASS → bypass applied. STAT_PKT_CNT=2.
- Back-pressure: hold OUT_READY=0 for 5 cycles with a continuous IN_VALID stream → IN_READY=0 after 2 beats are accepted, OUT_* stable, and no beat lost or duplicated on release. Asserting RESET mid-packet → OUT_VALID=0 next cycle, counters 0, FSM in IDLE.
